// File: rtl/mem_resp_pkg.sv
// Shared types and sizing for the memory bus responder and its response FIFO.
package mem_resp_pkg;

  localparam int MEM_DATA_SIZE = 4;
  localparam int MEM_TAG_WIDTH = 8;
  localparam int MEM_RSP_QUEUE = 4;

  localparam int WORD_W    = MEM_DATA_SIZE * 8;
  localparam int RSP_CNT_W = $clog2(MEM_RSP_QUEUE + 1);

  typedef struct packed {
    logic [WORD_W-1:0]        data;
    logic [MEM_TAG_WIDTH-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO, DEPTH entries, head read from registered storage; 1-cycle push-to-out_vld.
// Pushes are refused only when full without a same-cycle pop; out_dat holds while !out_rdy.
module mem_rsp_fifo
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = MEM_RSP_QUEUE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_vld,
  input  rsp_entry_t in_dat,
  output logic       full,
  input  logic       out_rdy,
  output logic       out_vld,
  output rsp_entry_t out_dat
);

  localparam int PW = $clog2(DEPTH);

  rsp_entry_t    store_q [DEPTH];
  rsp_entry_t    store_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop;

  assign out_vld = (cnt_q != '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign out_dat = store_q[rd_ptr_q];
  assign pop     = out_rdy && out_vld;
  // Full plus a same-cycle pop frees the head slot, so the push may land.
  assign push    = in_vld && (!full || pop);

  always_comb begin
    store_d  = store_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      store_d[wr_ptr_q] = in_dat;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      store_q  <= store_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(in_vld && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(out_rdy && !out_vld && pop));
`endif

endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus slave over a word-addressed sync SRAM; read response 2 cycles after request fire.
// Credit counter bounds outstanding responses to RSP_QUEUE; req_ready drops when credits run out.
module mem_bus_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_SIZE  = MEM_DATA_SIZE,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
  parameter int RSP_QUEUE  = MEM_RSP_QUEUE,
  parameter bit WRITE_ACK  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [DATA_SIZE-1:0]   req_byteen,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_SIZE*8-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [DATA_SIZE*8-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic                   busy
);

  logic [DATA_SIZE*8-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_SIZE*8-1:0] sram_rdata;

  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_wr_q,  s1_wr_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic [RSP_CNT_W-1:0] out_q,    out_d;

  logic       req_fire, rsp_fire, rsp_gen, fifo_full;
  rsp_entry_t push_dat, head_dat;

  // Credits count S1 and FIFO contents together, so the FIFO can never overflow.
  assign req_ready = (out_q != RSP_CNT_W'(RSP_QUEUE));
  assign busy      = (out_q != '0);
  assign req_fire  = req_valid && req_ready;
  assign rsp_gen   = req_fire && (!req_rw || WRITE_ACK);
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (req_fire) begin
      if (req_rw) begin
        for (int i = 0; i < DATA_SIZE; i++) begin
          if (req_byteen[i]) begin
            mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
          end
        end
      end else begin
        sram_rdata <= mem[req_addr];
      end
    end
  end

  always_comb begin
    s1_vld_d = rsp_gen;
    s1_wr_d  = req_rw;
    s1_tag_d = req_tag;
    case ({rsp_gen, rsp_fire})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_wr_q  <= 1'b0;
      s1_tag_q <= '0;
      out_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_wr_q  <= s1_wr_d;
      s1_tag_q <= s1_tag_d;
      out_q    <= out_d;
    end
  end

  // Write acks return zero data rather than whatever the SRAM output last held.
  always_comb begin
    push_dat      = '0;
    push_dat.data = s1_wr_q ? '0 : sram_rdata;
    push_dat.tag  = s1_tag_q;
  end

  mem_rsp_fifo #(
    .DEPTH(RSP_QUEUE)
  ) u_rsp_fifo (
    .clk    (clk),
    .reset  (reset),
    .in_vld (s1_vld_q),
    .in_dat (push_dat),
    .full   (fifo_full),
    .out_rdy(rsp_ready),
    .out_vld(rsp_valid),
    .out_dat(head_dat)
  );

  assign rsp_data = head_dat.data;
  assign rsp_tag  = head_dat.tag;

`ifndef SYNTHESIS
  a_params:    assert property (@(posedge clk)
                 (DATA_SIZE == MEM_DATA_SIZE) && (TAG_WIDTH == MEM_TAG_WIDTH) && (RSP_QUEUE == MEM_RSP_QUEUE));
  a_credit:    assert property (@(posedge clk) disable iff (reset) out_q <= RSP_CNT_W'(RSP_QUEUE));
  a_no_under:  assert property (@(posedge clk) disable iff (reset) !(rsp_fire && out_q == '0));
  a_fifo_room: assert property (@(posedge clk) disable iff (reset) !(s1_vld_q && fifo_full && !rsp_ready));
  a_req_hold:  assert property (@(posedge clk) disable iff (reset) (req_valid && !req_ready) |=> req_valid);
`endif

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Slave-side endpoint for the core's memory bus request/response interface, the responder the core's icache/dcache master ports talk to.
- Backs the bus with a single-port synchronous word-addressed SRAM. Used as a local scratchpad and as a cache stand-in for core-level simulation.
- Accepts one request per cycle, applies byte-enabled writes, and returns tagged read responses in order.
- A credit counter prevents response-queue overflow under rsp_ready backpressure.

Parameters:
DATA_SIZE, 4, word size in bytes (power of 2)
ADDR_WIDTH, 10, word-address width; memory depth = 2^ADDR_WIDTH words
TAG_WIDTH, 8, request/response tag width
RSP_QUEUE, 4, response FIFO depth and maximum outstanding responses (>=2, power of 2)
WRITE_ACK, 0, 1 = writes also return a response (data field zero)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_rw  in  1  1 = write, 0 = read
req_byteen  in  DATA_SIZE  write byte enables
req_addr  in  ADDR_WIDTH  word address
req_data  in  DATA_SIZE*8  write data
req_tag  in  TAG_WIDTH  request tag
req_ready  out  1  request accepted when valid&&ready
rsp_valid  out  1  response valid
rsp_data  out  DATA_SIZE*8  read data
rsp_tag  out  TAG_WIDTH  tag echoed from request
rsp_ready  in  1  response consumed when valid&&ready
busy  out  1  any response outstanding

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0.
- Reset clears the outstanding counter, the S1 pipeline register and the FIFO. SRAM contents are not reset.
- Reset mid-operation drops pending responses. Writes already fired stay committed.
- Request fire = req_valid && req_ready.
- On write fire, SRAM byte i is updated iff req_byteen[i]=1.
- A "response-producing" fire is a read, or a write when WRITE_ACK=1.
- Pipeline:
  - Cycle T: request fires.
  - T+1: SRAM output and tag are registered in S1 and enqueued.
  - T+2: earliest rsp_valid=1.
  - Minimum latency is 2 cycles. There is no bypass.
- Ordering: responses leave in request order. A read fired after a write to the same address returns the new data, even when the two fire back-to-back.
- Credit counter `outstanding`, width clog2(RSP_QUEUE+1):
  - +1 on a response-producing fire.
  - -1 on rsp fire.
  - Both in the same cycle: unchanged.
- req_ready = (outstanding != RSP_QUEUE). It is registered-state only, with no combinational path from rsp_ready or req_*. It is uniform for reads and writes.
- FIFO never overflows: S1 plus FIFO occupancy never exceeds outstanding.
- Full FIFO with a simultaneous enqueue and dequeue is legal. Occupancy is unchanged and data is preserved.
- rsp_valid = FIFO non-empty.
- rsp_data and rsp_tag stay stable while rsp_valid && !rsp_ready.
- busy = (outstanding != 0).
- With WRITE_ACK=1, the write response has rsp_data=0 and carries the write's tag.
- Address is a word address. There is no bounds error, because the full ADDR_WIDTH space is implemented.
- Assertions (simulation only): no FIFO overflow or underflow; outstanding never exceeds RSP_QUEUE; req_valid must not drop before fire.

Decomposition:
- Shared package mem_resp_pkg:
  - rsp_entry_t struct {data, tag}.
  - Localparams RSP_CNT_W = clog2(RSP_QUEUE+1) and WORD_W = DATA_SIZE*8.
- One sub-module: mem_rsp_fifo. Synchronous FIFO of rsp_entry_t, depth RSP_QUEUE, registered outputs, with push/pop, empty/full, and simultaneous push+pop allowed when full.
- The SRAM is inline behavioural RTL in this block, with a per-byte write-enable loop.

Test Plan:
- Write addr 0x010 data 0xDEADBEEF byteen 0xF, then read 0x010 tag 0x5A in the next cycle -> rsp_valid at read fire+2, rsp_data=0xDEADBEEF, rsp_tag=0x5A; no response for the write (WRITE_ACK=0).
- Partial write 0x11223344 byteen 0x3 over 0xDEADBEEF at 0x010, then read -> 0xDEAD3344.
- rsp_ready held 0, reads fired every cycle -> exactly 4 accepted, req_ready=0 after the 4th, busy=1. Release rsp_ready -> 4 responses in tag order 0,1,2,3. req_ready returns to 1 the cycle after the first rsp fire.
- Steady state with FIFO full and rsp_ready=1, reads every cycle -> one response per cycle, no tag lost or duplicated, outstanding constant at RSP_QUEUE-1 or RSP_QUEUE.
- Assert reset with 3 reads outstanding -> next cycle rsp_valid=0, busy=0, req_ready=1. A following read of a previously written address still returns the written data.
- WRITE_ACK=1: write tag 0x07 -> response at fire+2 with rsp_tag=0x07, rsp_data=0. Interleave write/read/write -> three responses in order.
